// File: rtl/vta_debug_responder.sv
// Debug-access responder: executes one host command at a time against the
// fetch control register and the on-chip memory ports, then returns one response.
module vta_debug_responder #(
    parameter int unsigned NUM_MEMS  = 4,
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned MEM_WORDS = 1,
    parameter int unsigned REG_WORDS = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_opcode,
    input  logic [31:0]                   cmd_id,
    input  logic [31:0]                   cmd_mask,
    input  logic [31:0]                   cmd_in,
    input  logic [31:0]                   cmd_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_err,
    input  logic [REG_WORDS*32-1:0]       reg_rdata,
    output logic                          reg_we,
    output logic [REG_WORDS*32-1:0]       reg_wdata,
    output logic [NUM_MEMS-1:0]           mem_en,
    output logic                          mem_we,
    output logic [MEM_AW-1:0]             mem_addr,
    output logic [MEM_WORDS*32-1:0]       mem_wdata,
    input  logic [NUM_MEMS*MEM_WORDS*32-1:0] mem_rdata,
    output logic [15:0]                   err_count
);

    localparam int unsigned RW  = REG_WORDS * 32;
    localparam int unsigned MW  = MEM_WORDS * 32;
    localparam int unsigned IW  = (NUM_MEMS  > 1) ? $clog2(NUM_MEMS)  : 1;
    localparam int unsigned RLW = (REG_WORDS > 1) ? $clog2(REG_WORDS) : 1;
    localparam int unsigned MLW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned LW  = (RLW > MLW) ? RLW : MLW;

    localparam logic [2:0]  OP_NOP  = 3'd0;
    localparam logic [2:0]  OP_WREG = 3'd1;
    localparam logic [2:0]  OP_RREG = 3'd2;
    localparam logic [2:0]  OP_WMEM = 3'd3;
    localparam logic [2:0]  OP_RMEM = 3'd4;
    localparam logic [31:0] NOP_DATA = 32'hdeadbeef;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEMRD,
        RESP
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [IW-1:0]    id_q;
    logic [LW-1:0]    lane_q;
    logic [31:0]      in_q;
    logic             err_q;

    logic             cmd_bad;
    logic             in_is_reg;
    logic             in_is_mem;
    logic [31:0]      reg_lane;
    logic [MW-1:0]    port_word;
    logic [31:0]      mem_lane;

    // Replace one 32-bit lane of a register value.
    function automatic logic [RW-1:0] reg_merge(input logic [RW-1:0] old,
                                                input logic [LW-1:0] lane,
                                                input logic [31:0]   d);
        logic [RW-1:0] r;
        r = old;
        for (int i = 0; i < int'(REG_WORDS); i++) begin
            if (LW'(i) == lane) r[i*32 +: 32] = d;
        end
        return r;
    endfunction

    // Replace one 32-bit lane of a memory word.
    function automatic logic [MW-1:0] mem_merge(input logic [MW-1:0] old,
                                                input logic [LW-1:0] lane,
                                                input logic [31:0]   d);
        logic [MW-1:0] r;
        r = old;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            if (LW'(i) == lane) r[i*32 +: 32] = d;
        end
        return r;
    endfunction

    // One-hot port enable from a validated port id.
    function automatic logic [NUM_MEMS-1:0] port_sel(input logic [IW-1:0] id);
        logic [NUM_MEMS-1:0] r;
        r = '0;
        for (int p = 0; p < int'(NUM_MEMS); p++) begin
            if (IW'(p) == id) r[p] = 1'b1;
        end
        return r;
    endfunction

    // Classify and validate the command on the input channel.
    always_comb begin
        in_is_reg = (cmd_opcode == {29'd0, OP_WREG}) || (cmd_opcode == {29'd0, OP_RREG});
        in_is_mem = (cmd_opcode == {29'd0, OP_WMEM}) || (cmd_opcode == {29'd0, OP_RMEM});
        cmd_bad   = 1'b0;
        if (cmd_opcode > 32'd4) begin
            cmd_bad = 1'b1;
        end else if (in_is_reg) begin
            cmd_bad = (cmd_id != 32'd0) || (cmd_mask >= 32'(REG_WORDS));
        end else if (in_is_mem) begin
            cmd_bad = (cmd_id >= 32'(NUM_MEMS)) || (cmd_mask >= 32'(MEM_WORDS)) ||
                      ((cmd_addr >> MEM_AW) != 32'd0);
        end
    end

    // Lane of the control register selected by the latched mask.
    always_comb begin
        reg_lane = '0;
        for (int i = 0; i < int'(REG_WORDS); i++) begin
            if (LW'(i) == lane_q) reg_lane = reg_rdata[i*32 +: 32];
        end
    end

    // Read word of the latched port, and the latched lane within it.
    always_comb begin
        port_word = '0;
        for (int p = 0; p < int'(NUM_MEMS); p++) begin
            if (IW'(p) == id_q) port_word = mem_rdata[p*MW +: MW];
        end
        mem_lane = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            if (LW'(i) == lane_q) mem_lane = port_word[i*32 +: 32];
        end
    end

    // Read data only lands in the write cycle, so the merged word follows it directly.
    assign mem_wdata = mem_we ? mem_merge(port_word, lane_q, in_q) : '0;

    // Command sequencer: accept, execute, optional memory read phase, respond.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            reg_we    <= 1'b0;
            reg_wdata <= '0;
            mem_en    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            err_count <= '0;
            op_q      <= '0;
            id_q      <= '0;
            lane_q    <= '0;
            in_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= EXEC;
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_opcode[2:0];
                        id_q      <= cmd_id[IW-1:0];
                        lane_q    <= cmd_mask[LW-1:0];
                        in_q      <= cmd_in;
                        err_q     <= cmd_bad;
                        // Strobes are launched at accept so they are live during EXEC.
                        if (!cmd_bad && (cmd_opcode == {29'd0, OP_WREG})) begin
                            reg_we    <= 1'b1;
                            reg_wdata <= reg_merge(reg_rdata, cmd_mask[LW-1:0], cmd_in);
                        end
                        if (!cmd_bad && in_is_mem) begin
                            mem_en   <= port_sel(cmd_id[IW-1:0]);
                            mem_we   <= 1'b0;
                            mem_addr <= cmd_addr[MEM_AW-1:0];
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    reg_we  <= 1'b0;
                    rsp_err <= err_q;
                    if (err_q) begin
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    end else begin
                        unique case (op_q)
                            OP_NOP: begin
                                rsp_data  <= NOP_DATA;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            OP_WREG: begin
                                rsp_data  <= '0;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            OP_RREG: begin
                                rsp_data  <= reg_lane;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            OP_WMEM: begin
                                mem_we <= 1'b1;
                                state  <= MEMRD;
                            end
                            default: begin
                                mem_en <= '0;
                                state  <= MEMRD;
                            end
                        endcase
                    end
                end
                MEMRD: begin
                    mem_en    <= '0;
                    mem_we    <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= (op_q == OP_RMEM) ? mem_lane : 32'd0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vta_debug_responder.sv
// Directed bench for vta_debug_responder with a register and memory model.
module tb_vta_debug_responder;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_opcode;
    logic [31:0]       cmd_id;
    logic [31:0]       cmd_mask;
    logic [31:0]       cmd_in;
    logic [31:0]       cmd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [31:0]       reg_rdata;
    logic              reg_we;
    logic [31:0]       reg_wdata;
    logic [NM-1:0]     mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic [NM*32-1:0]  mem_rdata;
    logic [15:0]       err_count;

    bit [31:0] reg_q;
    bit [31:0] mem_model [NM][1024];
    bit [31:0] mem_rd [NM];

    int n_cmp = 0;
    int n_bad = 0;

    int          r_lat;
    int          r_strobes;
    int          r_regwe;
    logic [31:0] r_regwdata;
    logic [31:0] r_data;
    logic        r_err;
    logic [NM-1:0] r_en1, r_en2;
    logic        r_we1, r_we2;
    logic [AW-1:0] r_addr1;
    logic [31:0] r_wdata2;

    always #5 clock = ~clock;

    vta_debug_responder dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_id     (cmd_id),
        .cmd_mask   (cmd_mask),
        .cmd_in     (cmd_in),
        .cmd_addr   (cmd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .reg_rdata  (reg_rdata),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .err_count  (err_count)
    );

    // Control register model.
    assign reg_rdata = reg_q;
    always @(posedge clock) begin
        if (reg_we) reg_q <= reg_wdata;
    end

    // Synchronous-read memory ports, read-before-write.
    always @(posedge clock) begin
        for (int p = 0; p < int'(NM); p++) begin
            if (mem_en[p]) begin
                mem_rd[p] <= mem_model[p][mem_addr];
                if (mem_we) mem_model[p][mem_addr] <= mem_wdata;
            end
        end
    end
    assign mem_rdata = {mem_rd[3], mem_rd[2], mem_rd[1], mem_rd[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a command and return one cycle after the accepting edge.
    task automatic send(input logic [31:0] op, input logic [31:0] id, input logic [31:0] mask,
                        input logic [31:0] din, input logic [31:0] addr);
        int w;
        cmd_opcode = op;
        cmd_id     = id;
        cmd_mask   = mask;
        cmd_in     = din;
        cmd_addr   = addr;
        cmd_valid  = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Run a full command with rsp_ready high, recording strobes and latency.
    task automatic do_cmd(input logic [31:0] op, input logic [31:0] id, input logic [31:0] mask,
                          input logic [31:0] din, input logic [31:0] addr);
        send(op, id, mask, din, addr);
        r_lat = 0; r_strobes = 0; r_regwe = 0; r_regwdata = '0;
        r_data = '0; r_err = 1'b0; r_en1 = '0; r_en2 = '0;
        r_we1 = 1'b0; r_we2 = 1'b0; r_addr1 = '0; r_wdata2 = '0;
        for (int k = 1; k <= 20; k++) begin
            if (reg_we) begin
                r_regwe++;
                r_regwdata = reg_wdata;
            end
            if (reg_we || (mem_en != '0) || mem_we) r_strobes++;
            if (k == 1) begin
                r_en1 = mem_en; r_we1 = mem_we; r_addr1 = mem_addr;
            end
            if (k == 2) begin
                r_en2 = mem_en; r_we2 = mem_we; r_wdata2 = mem_wdata;
            end
            if (rsp_valid) begin
                r_lat  = k;
                r_data = rsp_data;
                r_err  = rsp_err;
                break;
            end
            tick();
        end
        if (r_lat == 0) check("rsp_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cyc;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        rsp_ready  = 1'b1;
        cmd_opcode = '0;
        cmd_id     = '0;
        cmd_mask   = '0;
        cmd_in     = '0;
        cmd_addr   = '0;
        tick();
        tick();

        // Values held in reset.
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_strobes",   {27'd0, reg_we, mem_en}, 32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_reg_wdata", reg_wdata,      32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b1;
        tick();
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);

        // nop
        do_cmd(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check("nop_lat",     32'(r_lat),     32'd2);
        check("nop_data",    r_data,         32'hdeadbeef);
        check("nop_err",     32'(r_err),     32'd0);
        check("nop_strobes", 32'(r_strobes), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // write reg then read reg
        do_cmd(32'd1, 32'd0, 32'd0, 32'h0000_0042, 32'd0);
        check("wreg_lat",    32'(r_lat),   32'd2);
        check("wreg_pulses", 32'(r_regwe), 32'd1);
        check("wreg_wdata",  r_regwdata,   32'h42);
        check("wreg_data",   r_data,       32'd0);
        check("wreg_err",    32'(r_err),   32'd0);
        do_cmd(32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        check("rreg_lat",  32'(r_lat), 32'd2);
        check("rreg_data", r_data,     32'h42);

        // write mem then read mem
        do_cmd(32'd3, 32'd2, 32'd0, 32'hCAFE_F00D, 32'd5);
        check("wmem_en1",    32'(r_en1),   32'h4);
        check("wmem_we1",    32'(r_we1),   32'd0);
        check("wmem_addr1",  32'(r_addr1), 32'd5);
        check("wmem_en2",    32'(r_en2),   32'h4);
        check("wmem_we2",    32'(r_we2),   32'd1);
        check("wmem_wdata2", r_wdata2,     32'hCAFE_F00D);
        check("wmem_lat",    32'(r_lat),   32'd3);
        check("wmem_data",   r_data,       32'd0);
        check("wmem_model",  mem_model[2][5], 32'hCAFE_F00D);
        do_cmd(32'd4, 32'd2, 32'd0, 32'd0, 32'd5);
        check("rmem_en1",  32'(r_en1), 32'h4);
        check("rmem_we1",  32'(r_we1), 32'd0);
        check("rmem_en2",  32'(r_en2), 32'd0);
        check("rmem_lat",  32'(r_lat), 32'd3);
        check("rmem_data", r_data,     32'hCAFE_F00D);
        check("rmem_err",  32'(r_err), 32'd0);

        // rejected commands
        do_cmd(32'd7, 32'd0, 32'd0, 32'd0, 32'd0);
        check("e_op_lat",  32'(r_lat), 32'd2);
        check("e_op_err",  32'(r_err), 32'd1);
        check("e_op_data", r_data,     32'd0);
        check("e_op_strb", 32'(r_strobes), 32'd0);
        do_cmd(32'd3, 32'd4, 32'd0, 32'h1111_1111, 32'd5);
        check("e_id_err",  32'(r_err), 32'd1);
        check("e_id_data", r_data,     32'd0);
        check("e_id_strb", 32'(r_strobes), 32'd0);
        do_cmd(32'd4, 32'd0, 32'd0, 32'd0, 32'h400);
        check("e_addr_err",  32'(r_err), 32'd1);
        check("e_addr_data", r_data,     32'd0);
        check("e_addr_strb", 32'(r_strobes), 32'd0);
        check("err_count3",  32'(err_count), 32'd3);

        // back-pressure on a read-mem response
        rsp_ready = 1'b0;
        send(32'd4, 32'd2, 32'd0, 32'd0, 32'd5);
        tick();
        tick();
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data",  rsp_data,       32'hCAFE_F00D);
        bad_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(rsp_valid && (rsp_data == 32'hCAFE_F00D) && !rsp_err &&
                  !cmd_ready && (mem_en == '0) && !mem_we)) bad_cyc++;
        end
        check("hold_stable", 32'(bad_cyc), 32'd0);
        rsp_ready = 1'b1;
        check("hold_release_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("after_release_ready", 32'(cmd_ready), 32'd1);
        check("after_release_valid", 32'(rsp_valid), 32'd0);

        // reset during the write cycle of a write-mem
        send(32'd3, 32'd1, 32'd0, 32'h1234_5678, 32'd7);
        tick();
        check("mid_we_before", 32'(mem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_en_drop",    32'(mem_en),    32'd0);
        check("mid_we_drop",    32'(mem_we),    32'd0);
        check("mid_wdata_drop", mem_wdata,      32'd0);
        check("mid_rsp_valid",  32'(rsp_valid), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready",  32'(cmd_ready), 32'd1);
        check("post_rst_errcnt", 32'(err_count), 32'd0);
        check("post_rst_valid",  32'(rsp_valid), 32'd0);
        check("post_rst_model",  mem_model[1][7], 32'd0);
        do_cmd(32'd4, 32'd1, 32'd0, 32'd0, 32'd7);
        check("post_rst_rdata", r_data,     32'd0);
        check("post_rst_rlat",  32'(r_lat), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
